// File: rtl/imem_icache_pkg.sv
// imem_icache_pkg: shared state type, default geometry and address-field helpers
package imem_icache_pkg;
   typedef enum logic {IDLE, FILL} state_t;
   localparam int NUM_LINES_D = 16;
   localparam int LINE_WORDS_D = 4;
   localparam int OFF_W = $clog2(LINE_WORDS_D);
   localparam int IDX_W = $clog2(NUM_LINES_D);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   function automatic logic [31:0] addr_off(input logic [31:0] a, input int off_w);
      return (a >> 2) & ((32'd1 << off_w) - 32'd1);
   endfunction
   function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
      return (a >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
   endfunction
   function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
      return a >> (2 + off_w + idx_w);
   endfunction
   function automatic logic [31:0] line_base(input logic [31:0] a, input int off_w);
      return a & ~((32'd1 << (off_w + 2)) - 32'd1);
   endfunction
endpackage

// File: rtl/imem_icache_fill_ctrl.sv
// imem_icache_fill_ctrl: line-fill FSM with pipelined memory requests and in-order responses
module imem_icache_fill_ctrl import imem_icache_pkg::*; #(
   parameter int LINE_WORDS = LINE_WORDS_D
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic [31:0]                   i_base,
   input  logic                          i_mem_ready,
   input  logic                          i_mem_valid,
   output logic                          o_busy,
   output logic                          o_mem_ren,
   output logic [31:0]                   o_mem_addr,
   output logic [31:0]                   o_base,
   output logic                          o_wr_en,
   output logic [$clog2(LINE_WORDS)-1:0] o_wr_off,
   output logic                          o_done
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int CW = OW + 1;
   localparam logic [CW-1:0] LW = CW'(LINE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
   state_t state, state_d;
   logic [CW-1:0] req_cnt, resp_cnt;
   logic [31:0] base;
   logic start, fire;
   always_comb begin
      start = (state == IDLE) & i_start;
      o_busy = state == FILL;
      o_mem_ren = o_busy & (req_cnt < LW);
      o_mem_addr = o_mem_ren ? base + (32'(req_cnt) << 2) : '0;
      o_base = base;
      fire = o_mem_ren & i_mem_ready;
      o_wr_en = o_busy & i_mem_valid & ~i_rst;
      o_wr_off = resp_cnt[OW-1:0];
      o_done = o_wr_en & (resp_cnt == LAST);
      state_d = start ? FILL : o_done ? IDLE : state;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         req_cnt <= '0;
         resp_cnt <= '0;
         base <= '0;
      end else begin
         state <= state_d;
         req_cnt <= start ? '0 : req_cnt + CW'(fire);
         resp_cnt <= start ? '0 : resp_cnt + CW'(o_wr_en);
         base <= start ? i_base : base;
      end
   end
   // responses arrive only for accepted requests
   always_ff @(posedge i_clk) if (!i_rst) assert (resp_cnt <= req_cnt);
endmodule

// File: rtl/imem_icache.sv
// imem_icache: direct-mapped read-only instruction cache with same-cycle hits
module imem_icache import imem_icache_pkg::*; #(
   parameter int          NUM_LINES  = NUM_LINES_D,
   parameter int          LINE_WORDS = LINE_WORDS_D,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_en,
   input  logic [31:0] i_req_addr,
   output logic [31:0] o_res_rdata,
   output logic        o_res_valid,
   output logic        o_busy,
   output logic        o_mem_ren,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ready,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_rdata
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 30 - OW - IW;
   if ((1 << OW) != LINE_WORDS || (1 << IW) != NUM_LINES || OW < 1 || IW < 1 || RESET_ADDR % 4 != 0) begin : g_bad_cfg
      $error("imem_icache: geometry must be powers of two >= 2 and RESET_ADDR word aligned");
   end
   logic [NUM_LINES-1:0] valid;
   logic [TW-1:0] tag_mem [NUM_LINES];
   logic [31:0] data_mem [NUM_LINES][LINE_WORDS];
   logic [OW-1:0] off, wr_off;
   logic [IW-1:0] idx, fill_idx;
   logic [TW-1:0] tag, fill_tag;
   logic [31:0] fill_base;
   logic fill_busy, hit, miss, wr_en, fill_done;
   always_comb begin
      off = OW'(addr_off(i_req_addr, OW));
      idx = IW'(addr_idx(i_req_addr, OW, IW));
      tag = TW'(addr_tag(i_req_addr, OW, IW));
      fill_idx = IW'(addr_idx(fill_base, OW, IW));
      fill_tag = TW'(addr_tag(fill_base, OW, IW));
      hit = i_req_en & ~fill_busy & valid[idx] & (tag_mem[idx] == tag);
      miss = i_req_en & ~fill_busy & ~hit;
      o_res_valid = hit;
      o_res_rdata = hit ? data_mem[idx][off] : '0;
      o_busy = miss | fill_busy;
   end
   imem_icache_fill_ctrl #(.LINE_WORDS(LINE_WORDS)) u_fill (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_start(miss),
      .i_base(line_base(i_req_addr, OW)),
      .i_mem_ready(i_mem_ready),
      .i_mem_valid(i_mem_valid),
      .o_busy(fill_busy),
      .o_mem_ren(o_mem_ren),
      .o_mem_addr(o_mem_addr),
      .o_base(fill_base),
      .o_wr_en(wr_en),
      .o_wr_off(wr_off),
      .o_done(fill_done)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) valid <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
   end
   // tag and data arrays are not reset; the valid bit alone gates them
   always_ff @(posedge i_clk) begin
      if (wr_en) data_mem[fill_idx][wr_off] <= i_mem_rdata;
      if (fill_done) tag_mem[fill_idx] <= fill_tag;
   end
   always_ff @(posedge i_clk) if (!i_rst) assert (!(o_res_valid && o_busy));
endmodule
